// File: rtl/dman_frame_sync_if.sv
// Bit-stream input and deframed byte/verdict outputs of the frame synchroniser.
interface dman_frame_sync_if;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sof;
  logic       eof;
  logic       frame_ok;
  logic       frame_err;
  logic       len_err;
  logic       locked;

  modport master (
    output bit_in, bit_valid,
    input  byte_out, byte_valid, sof, eof, frame_ok, frame_err, len_err, locked
  );

  modport slave (
    input  bit_in, bit_valid,
    output byte_out, byte_valid, sof, eof, frame_ok, frame_err, len_err, locked
  );
endinterface

// File: rtl/dman_frame_sync.sv
// Frame synchroniser/deframer: sync-word hunt, length byte, payload, CRC-8 check.
// Payload bytes stream out unbuffered; the verdict pulse follows the last byte.
module dman_frame_sync #(
  parameter int                SYNC_W    = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 16'hD391,
  parameter int                MAX_LEN   = 64,
  parameter logic [7:0]        CRC_POLY  = 8'h07,
  parameter logic [7:0]        CRC_INIT  = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  dman_frame_sync_if.slave  bus
);

  localparam int HCW = $clog2(SYNC_W + 1);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CRC     = 2'd3
  } state_t;

  state_t            state_q;
  logic [SYNC_W-1:0] sr_q;
  logic [HCW-1:0]    hunt_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        len_q;
  logic [7:0]        byte_cnt_q;
  logic [7:0]        crc_q;
  logic [7:0]        byte_out_q;
  logic              byte_valid_q;
  logic              sof_q;
  logic              eof_q;
  logic              frame_ok_q;
  logic              frame_err_q;
  logic              len_err_q;
  logic              locked_q;

  logic [SYNC_W-1:0] sr_d;
  logic [7:0]        byte_d;
  logic [7:0]        crc_d;
  logic              hunt_hit_d;
  logic              byte_done_d;
  logic              last_byte_d;

  // Bitwise MSB-first CRC-8 over one byte, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? CRC_POLY : 8'h00);
    end
    return c;
  endfunction

  assign sr_d        = {sr_q[SYNC_W-2:0], bus.bit_in};
  assign byte_d      = {shift_q[6:0], bus.bit_in};
  assign crc_d       = crc8_byte(crc_q, byte_d);
  assign byte_done_d = (bit_cnt_q == 3'd7);
  assign last_byte_d = (byte_cnt_q == (len_q - 8'd1));
  // The incoming bit is the SYNC_W-th (or later) fresh bit when the count already holds SYNC_W-1.
  assign hunt_hit_d  = (sr_d == SYNC_WORD) && (hunt_cnt_q >= HCW'(SYNC_W - 1));

  // Deframer FSM with all outputs registered; state moves only on bit_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HUNT;
      sr_q         <= '0;
      hunt_cnt_q   <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      len_q        <= 8'h00;
      byte_cnt_q   <= 8'h00;
      crc_q        <= CRC_INIT;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      len_err_q    <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      len_err_q    <= 1'b0;
      if (bus.bit_valid) begin
        if (state_q != S_HUNT) begin
          shift_q   <= byte_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end else begin
          shift_q   <= shift_q;
          bit_cnt_q <= bit_cnt_q;
        end
        case (state_q)
          S_HUNT: begin
            sr_q <= sr_d;
            if (hunt_cnt_q != HCW'(SYNC_W)) begin
              hunt_cnt_q <= hunt_cnt_q + HCW'(1);
            end else begin
              hunt_cnt_q <= hunt_cnt_q;
            end
            if (hunt_hit_d) begin
              state_q   <= S_LEN;
              bit_cnt_q <= 3'd0;
              crc_q     <= CRC_INIT;
              locked_q  <= 1'b1;
            end else begin
              state_q <= S_HUNT;
            end
          end
          S_LEN: begin
            if (byte_done_d) begin
              if ((byte_d == 8'd0) || (byte_d > 8'(MAX_LEN))) begin
                len_err_q  <= 1'b1;
                state_q    <= S_HUNT;
                sr_q       <= '0;
                hunt_cnt_q <= '0;
                locked_q   <= 1'b0;
              end else begin
                len_q      <= byte_d;
                crc_q      <= crc_d;
                byte_cnt_q <= 8'h00;
                state_q    <= S_PAYLOAD;
              end
            end else begin
              state_q <= S_LEN;
            end
          end
          S_PAYLOAD: begin
            if (byte_done_d) begin
              byte_out_q   <= byte_d;
              byte_valid_q <= 1'b1;
              sof_q        <= (byte_cnt_q == 8'h00);
              eof_q        <= last_byte_d;
              crc_q        <= crc_d;
              byte_cnt_q   <= byte_cnt_q + 8'd1;
              state_q      <= last_byte_d ? S_CRC : S_PAYLOAD;
            end else begin
              state_q <= S_PAYLOAD;
            end
          end
          S_CRC: begin
            if (byte_done_d) begin
              frame_ok_q  <= (byte_d == crc_q);
              frame_err_q <= (byte_d != crc_q);
              state_q     <= S_HUNT;
              sr_q        <= '0;
              hunt_cnt_q  <= '0;
              locked_q    <= 1'b0;
            end else begin
              state_q <= S_CRC;
            end
          end
          default: begin
            state_q    <= S_HUNT;
            sr_q       <= '0;
            hunt_cnt_q <= '0;
            locked_q   <= 1'b0;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.sof        = sof_q;
  assign bus.eof        = eof_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.len_err    = len_err_q;
  assign bus.locked     = locked_q;

endmodule
